// File: rtl/count_chk_pkg.sv
// Shared types and default widths for the counter sequence checker and its
// prediction helper.
package count_chk_pkg;

  localparam int CHK_CW = 4;
  localparam int CHK_EW = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SYNC   = 2'd1,
    LOCKED = 2'd2,
    FAULT  = 2'd3
  } chk_state_t;

endpackage

// File: rtl/count_predict.sv
// Combinational next-value model of an up/down loadable counter with its own
// reset; wrap-around falls out of the modulo-2^CW arithmetic.
module count_predict
  import count_chk_pkg::*;
#(
  parameter int CW = CHK_CW
) (
  input  logic [CW-1:0] q,
  input  logic          S,
  input  logic          up_and_down,
  input  logic          cnt_rst,
  input  logic [CW-1:0] D,
  output logic [CW-1:0] next
);

  // Priority: counter reset, then load, then count direction.
  always_comb begin
    next = '0;
    if (cnt_rst) begin
      next = '0;
    end else if (S) begin
      next = D;
    end else if (up_and_down) begin
      next = q + CW'(1);
    end else begin
      next = q - CW'(1);
    end
  end

endmodule

// File: rtl/count_sequence_checker.sv
// Watches an external up/down counter, predicts its next value each cycle and
// flags any cycle where the observed output departs from the prediction.
module count_sequence_checker
  import count_chk_pkg::*;
#(
  parameter int CW = CHK_CW,
  parameter int EW = CHK_EW
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          en,
  input  logic          cnt_rst,
  input  logic          S,
  input  logic          up_and_down,
  input  logic [CW-1:0] D,
  input  logic [CW-1:0] qin,
  input  logic          clr,
  output logic          locked,
  output logic          err,
  output logic          sticky_err,
  output logic [EW-1:0] err_count,
  output logic [CW-1:0] expected,
  output logic [CW-1:0] first_bad
);

  chk_state_t    state_r;
  chk_state_t    state_nx_s;
  logic [CW-1:0] pred_s;
  logic [CW-1:0] expected_r;
  logic [EW-1:0] err_count_r;
  logic          sticky_r;
  logic [CW-1:0] first_bad_r;
  logic          compare_s;
  logic          mismatch_s;

  count_predict #(.CW(CW)) u_predict (
    .q           (qin),
    .S           (S),
    .up_and_down (up_and_down),
    .cnt_rst     (cnt_rst),
    .D           (D),
    .next        (pred_s)
  );

  assign compare_s  = en && ((state_r == LOCKED) || (state_r == FAULT));
  assign mismatch_s = compare_s && (qin != expected_r);

  // Next-state selection; dropping en always returns to IDLE.
  always_comb begin
    state_nx_s = state_r;
    if (!en) begin
      state_nx_s = IDLE;
    end else begin
      case (state_r)
        IDLE:    state_nx_s = SYNC;
        SYNC:    state_nx_s = LOCKED;
        LOCKED:  state_nx_s = mismatch_s ? FAULT : LOCKED;
        FAULT:   state_nx_s = mismatch_s ? FAULT : LOCKED;
        default: state_nx_s = IDLE;
      endcase
    end
  end

  // State, prediction and error bookkeeping; clr beats a coincident mismatch.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r     <= IDLE;
      expected_r  <= '0;
      err_count_r <= '0;
      sticky_r    <= 1'b0;
      first_bad_r <= '0;
    end else begin
      state_r <= state_nx_s;
      if (en && (state_r != IDLE)) begin
        expected_r <= pred_s;
      end
      if (clr) begin
        err_count_r <= '0;
        sticky_r    <= 1'b0;
        first_bad_r <= '0;
      end else if (mismatch_s) begin
        if (err_count_r != {EW{1'b1}}) begin
          err_count_r <= err_count_r + EW'(1);
        end
        sticky_r <= 1'b1;
        if (!sticky_r) begin
          first_bad_r <= qin;
        end
      end
    end
  end

  assign locked     = (state_r == LOCKED);
  assign err        = mismatch_s;
  assign sticky_err = sticky_r;
  assign err_count  = err_count_r;
  assign expected   = expected_r;
  assign first_bad  = first_bad_r;

endmodule

// File: tb/tb_count_sequence_checker.sv
// Directed-vector bench: each driven cycle queues its hand-derived expected
// outputs; a negedge monitor pops and compares them.
module tb_count_sequence_checker;

  logic       clk = 1'b0;
  logic       reset, en, cnt_rst, S, up_and_down, clr;
  logic [3:0] D, qin;
  logic       locked, err, sticky_err;
  logic [7:0] err_count;
  logic [3:0] expected, first_bad;

  typedef struct {
    int err; int lock; int exp; int cnt; int sticky; int fb;
  } exp_t;

  exp_t q_exp[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  count_sequence_checker #(.CW(4), .EW(8)) dut (
    .clk(clk), .reset(reset), .en(en), .cnt_rst(cnt_rst), .S(S),
    .up_and_down(up_and_down), .D(D), .qin(qin), .clr(clr),
    .locked(locked), .err(err), .sticky_err(sticky_err),
    .err_count(err_count), .expected(expected), .first_bad(first_bad)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int req);
    if (req >= 0) begin
      n_cmp++;
      if (act != req) begin
        n_bad++;
        $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
      end
    end
  endtask

  // -1 in any expected field means "don't care" for that cycle.
  task automatic cyc(input logic r, input logic e, input logic cr, input logic s,
                     input logic ud, input int d, input int q, input logic c,
                     input int x_err, input int x_lock, input int x_exp,
                     input int x_cnt, input int x_sticky, input int x_fb);
    exp_t t;
    @(posedge clk); #1;
    reset = r; en = e; cnt_rst = cr; S = s; up_and_down = ud;
    D = 4'(d); qin = 4'(q); clr = c;
    t.err = x_err; t.lock = x_lock; t.exp = x_exp;
    t.cnt = x_cnt; t.sticky = x_sticky; t.fb = x_fb;
    q_exp.push_back(t);
  endtask

  // Monitor: compare the outputs the DUT presents in each driven cycle.
  always @(negedge clk) begin
    if (q_exp.size() > 0) begin
      exp_t t;
      t = q_exp.pop_front();
      chk("err",        int'(err),        t.err);
      chk("locked",     int'(locked),     t.lock);
      chk("expected",   int'(expected),   t.exp);
      chk("err_count",  int'(err_count),  t.cnt);
      chk("sticky_err", int'(sticky_err), t.sticky);
      chk("first_bad",  int'(first_bad),  t.fb);
    end
  end

  initial begin
    reset = 1'b1; en = 1'b0; cnt_rst = 1'b0; S = 1'b0; up_and_down = 1'b1;
    D = 4'd0; qin = 4'd0; clr = 1'b0;

    // Reset, then reset values observed
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 0, 0, 1'b0, -1, -1, -1, -1, -1, -1);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 0, 0, 1'b0, 0, 0, 0, 0, 0, 0);
    // Up count with wrap: IDLE, SYNC, then locked
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 0, 0, 1'b0, 0, 0, -1, 0, 0, -1);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 0, 1, 1'b0, 0, 0, -1, 0, 0, -1);
    for (int k = 2; k <= 18; k++)
      cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 0, k % 16, 1'b0, 0, 1, k % 16, 0, 0, 0);
    // Down count across 0 -> 15
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 0, 3, 1'b0, 0, 1, 3, 0, 0, 0);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 0, 2, 1'b0, 0, 1, 2, 0, 0, 0);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 0, 1, 1'b0, 0, 1, 1, 0, 0, 0);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 0, 0, 1'b0, 0, 1, 0, 0, 0, 0);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 0, 15, 1'b0, 0, 1, 15, 0, 0, 0);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 0, 14, 1'b0, 0, 1, 14, 0, 0, 0);
    for (int k = 13; k >= 6; k--)
      cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 0, k, 1'b0, 0, 1, k, 0, 0, 0);
    // Load at q=5 with D=9
    cyc(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 9, 5, 1'b0, 0, 1, 5, 0, 0, 0);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 0, 9, 1'b0, 0, 1, 9, 0, 0, 0);
    // Load 3, count 3,4, glitch 7, recover 8,9
    cyc(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 3, 10, 1'b0, 0, 1, 10, 0, 0, 0);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 0, 3, 1'b0, 0, 1, 3, 0, 0, 0);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 0, 4, 1'b0, 0, 1, 4, 0, 0, 0);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 0, 7, 1'b0, 1, 1, 5, 0, 0, 0);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 0, 8, 1'b0, 0, 0, 8, 1, 1, 7);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 0, 9, 1'b0, 0, 1, 9, 1, 1, 7);
    // 300 consecutive mismatches: qin held at 10 while prediction is qin+1
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 0, 10, 1'b0, 0, 1, 10, 1, 1, 7);
    for (int i = 0; i < 300; i++)
      cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 0, 10, 1'b0,
          1, (i == 0) ? 1 : 0, 11, (i + 1 > 255) ? 255 : i + 1, 1, 7);
    // clr on a matching cycle in FAULT
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 0, 11, 1'b1, 0, 0, 11, 255, 1, 7);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 0, 12, 1'b0, 0, 1, 12, 0, 0, 0);
    // cnt_rst while locked predicts 0 and keeps lock
    cyc(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 0, 13, 1'b0, 0, 1, 13, 0, 0, 0);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 0, 0, 1'b0, 0, 1, 0, 0, 0, 0);
    // clr coinciding with a mismatch: clr wins, err still pulses
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 0, 0, 1'b1, 1, 1, 1, 0, 0, 0);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 0, 5, 1'b0, 1, 0, 1, 0, 0, 0);
    // Reset mid-FAULT, then en=0 keeps IDLE with no err
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 0, 3, 1'b0, -1, 0, 6, 1, 1, 5);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 0, 7, 1'b0, 0, 0, 0, 0, 0, 0);
    for (int k = 0; k < 6; k++)
      cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 0, (k * 5 + 3) % 16, 1'b0, 0, 0, 0, 0, 0, 0);

    for (int w = 0; w < 20 && q_exp.size() > 0; w++) @(posedge clk);
    n_cmp++;
    if (q_exp.size() != 0) begin
      n_bad++;
      $display("FAIL drain: %0d entries left, expected 0", q_exp.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/count_sequence_checker.md
COUNT_SEQUENCE_CHECKER -- requirements
Module: count_sequence_checker

Interface
REQ-001: Parameter CW, default 4, is the observed counter width in bits.
REQ-002: Parameter EW, default 8, is the error counter width in bits.
REQ-003: clk  input  1  sole clock; all state updates on the rising edge.
REQ-004: reset  input  1  synchronous, active-high reset of all checker state.
REQ-005: en  input  1  checking enable; low forces IDLE.
REQ-006: cnt_rst  input  1  observed counter's own reset, sampled alongside its controls.
REQ-007: S  input  1  observed counter's load select.
REQ-008: up_and_down  input  1  observed counter's direction select: 1 = up, 0 = down.
REQ-009: D  input  CW  observed counter's load data.
REQ-010: qin  input  CW  observed counter output.
REQ-011: clr  input  1  clears err_count, sticky_err and first_bad.
REQ-012: locked  output  1  high while in LOCKED.
REQ-013: err  output  1  single-cycle mismatch pulse.
REQ-014: sticky_err  output  1  set on any mismatch; held until clr or reset.
REQ-015: err_count  output  EW  saturating mismatch count.
REQ-016: expected  output  CW  registered prediction being compared this cycle.
REQ-017: first_bad  output  CW  qin value of the first mismatch since the last clear.

Function
REQ-018: Prediction from controls and q sampled in cycle n, for comparison against qin in cycle n+1, in priority order:
- cnt_rst -> 0
- S -> D
- up_and_down -> q+1 mod 2^CW
- otherwise -> q-1 mod 2^CW
REQ-019: Wrap-around is required: up from 2^CW-1 gives 0; down from 0 gives 2^CW-1.
REQ-020: States are IDLE, SYNC, LOCKED and FAULT.
REQ-021: IDLE -> SYNC when en=1; no compare is made in IDLE.
REQ-022: SYNC captures the prediction and goes to LOCKED next cycle; no compare is made in SYNC.
REQ-023: LOCKED compares qin with expected every cycle; on mismatch it goes to FAULT.
REQ-024: FAULT compares every cycle:
- match -> LOCKED
- mismatch -> stays in FAULT
REQ-025: In LOCKED and FAULT, the prediction is recomputed every cycle from the current qin and controls, so a single glitch causes exactly one err.
REQ-026: en=0 in any state -> IDLE next cycle; err_count, sticky_err and first_bad are retained.
REQ-027: err is asserted in the same cycle as the mismatching qin (combinational on registered expected) and is never asserted outside LOCKED/FAULT.
REQ-028: err_count increments by 1 per mismatch cycle and saturates at 2^EW-1 without wrapping.
REQ-029: first_bad loads qin only when sticky_err is 0 and a mismatch occurs.
REQ-030: On clr coinciding with a mismatch, clr wins: err_count = 0, sticky_err = 0, and err still pulses.
REQ-031: A cnt_rst pulse while LOCKED does not unlock; it predicts 0.

Reset
REQ-032: On reset=1 at a rising edge, the next-cycle values are:
- state = IDLE, locked = 0, err = 0
- sticky_err = 0, err_count = 0
- expected = 0, first_bad = 0
REQ-033: Reset overrides en, clr and all compares, and is honoured mid-FAULT or mid-LOCKED.

Structure
REQ-034: Shared package count_chk_pkg holds:
- state enum chk_state_t (IDLE, SYNC, LOCKED, FAULT)
- default-width constants CHK_CW=4 and CHK_EW=8
REQ-035: One combinational sub-module, count_predict, implements REQ-018 (inputs q, S, up_and_down, cnt_rst, D; output next) and is reusable by the bench's reference model.
REQ-036: All other logic (FSM, error bookkeeping) resides in count_sequence_checker.

Verification
REQ-037: Reset, en=1, up count 0..15..0 (wrapping) -> locked from the third cycle, err never asserted, err_count=0.
REQ-038: Locked, down count from 2: 2,1,0,15,14 -> no err at the 0->15 wrap.
REQ-039: Locked at q=5, S=1, D=9 -> expected=9 next cycle; qin=9 gives no err.
REQ-040: Locked up count 3,4, then qin=7 (glitch), then 8 -> err one cycle, first_bad=7, state FAULT then LOCKED, err_count=1.
REQ-041: Force 300 consecutive mismatches -> err_count saturates at 255; then clr -> err_count=0, sticky_err=0.
REQ-042: Mid-FAULT, assert reset for one cycle -> all outputs at reset values; then en=0 gives IDLE and no err regardless of qin.
